// File: rtl/conv5_pkg.sv
// Shared types and constants for the conv_5 sequencer.
// Optional macro CONV5_SEQ_PERF_EN adds the perf_cycles/perf_stalls counters.
package conv5_pkg;

    localparam int unsigned KERNEL_SIZE = 5;
    localparam int unsigned FP16_W      = 16;

    typedef logic [KERNEL_SIZE*FP16_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_K = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/conv5_pos_cnt.sv
// Column/band position tracker for the streamed image beats.
module conv5_pos_cnt
    import conv5_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             advance,
    input  logic [CNT_W-1:0] img_w,
    input  logic [CNT_W-1:0] img_h,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] band,
    output logic             win_full,
    output logic             last_beat
);

    logic col_end;
    logic band_end;

    // Wrap points and window/last-beat flags for the current position.
    always_comb begin
        col_end   = (col == CNT_W'(img_w - CNT_W'(1)));
        band_end  = (band == CNT_W'(img_h - CNT_W'(KERNEL_SIZE)));
        win_full  = (col >= CNT_W'(KERNEL_SIZE - 1));
        last_beat = col_end & band_end;
    end

    // Advance col per accepted beat; band steps when col wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col  <= '0;
            band <= '0;
        end else if (advance) begin
            if (col_end) begin
                col  <= '0;
                band <= band_end ? '0 : CNT_W'(band + CNT_W'(1));
            end else begin
                col  <= CNT_W'(col + CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/conv5_seq_ctrl.sv
// Job sequencer for one conv_5 engine: kernel load, band streaming, result return.
// Optional macro CONV5_SEQ_PERF_EN adds perf_cycles/perf_stalls outputs.
module conv5_seq_ctrl
    import conv5_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP16_W,
    parameter int unsigned IMG_MAX    = 32,
    parameter int unsigned CNT_W      = $clog2(IMG_MAX + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  cfg_img_w,
    input  logic [CNT_W-1:0]                  cfg_img_h,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    input  logic                              k_valid,
    output logic                              k_ready,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] k_data,
    input  logic                              px_valid,
    output logic                              px_ready,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] px_data,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_data,
    output logic                              conv_kernel_load,
    output logic                              conv_valid_in,
    output logic                              conv_valid_out,
    input  logic [DATA_WIDTH-1:0]             conv_data_out,
    output logic                              res_valid,
    output logic [DATA_WIDTH-1:0]             res_data,
    output logic                              res_last
`ifdef CONV5_SEQ_PERF_EN
    ,
    output logic [31:0]                       perf_cycles,
    output logic [31:0]                       perf_stalls
`endif
);

    localparam int unsigned KCNT_W = $clog2(KERNEL_SIZE);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   img_w_q;
    logic [CNT_W-1:0]   img_h_q;
    logic [KCNT_W-1:0]  k_cnt;
    logic               t0, t1, t2;
    logic               l0, l1, l2;
    logic               cfg_bad;
    logic               start_ok;
    logic               k_acc;
    logic               k_last;
    logic               px_acc;
    logic               line_empty;
    logic [CNT_W-1:0]   col;
    logic [CNT_W-1:0]   band;
    logic               win_full;
    logic               last_beat;
    logic               pos_unused;

    // Job qualification and handshake decodes.
    always_comb begin
        cfg_bad    = (cfg_img_w < CNT_W'(KERNEL_SIZE)) || (cfg_img_h < CNT_W'(KERNEL_SIZE)) ||
                     (cfg_img_w > CNT_W'(IMG_MAX))     || (cfg_img_h > CNT_W'(IMG_MAX));
        start_ok   = start && (state == IDLE) && !cfg_bad;
        k_acc      = (state == LOAD_K) && k_valid;
        k_last     = k_acc && (k_cnt == KCNT_W'(KERNEL_SIZE - 1));
        px_acc     = (state == STREAM) && px_valid;
        line_empty = !(t0 || t1 || t2);
        pos_unused = ^{col, band};
    end

    conv5_pos_cnt #(
        .CNT_W (CNT_W)
    ) u_pos_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .advance   (px_acc),
        .img_w     (img_w_q),
        .img_h     (img_h_q),
        .col       (col),
        .band      (band),
        .win_full  (win_full),
        .last_beat (last_beat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)            state_nxt = LOAD_K;
            LOAD_K:  if (k_last)              state_nxt = STREAM;
            STREAM:  if (px_acc && last_beat) state_nxt = DRAIN;
            DRAIN:   if (line_empty)          state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Per-state handshakes and engine controls; data passes straight through.
    always_comb begin
        busy             = (state != IDLE);
        done             = 1'b0;
        k_ready          = 1'b0;
        px_ready         = 1'b0;
        conv_kernel_load = 1'b0;
        conv_valid_in    = 1'b0;
        conv_data        = '0;
        case (state)
            LOAD_K: begin
                k_ready          = 1'b1;
                conv_kernel_load = 1'b1;
                conv_valid_in    = k_valid;
                conv_data        = k_data;
            end
            STREAM: begin
                px_ready      = 1'b1;
                conv_valid_in = px_valid;
                conv_data     = px_data;
            end
            DRAIN:   done = line_empty;
            default: ;
        endcase
        conv_valid_out = t1;
        res_valid      = t2;
        res_data       = t2 ? conv_data_out : '0;
        res_last       = t2 && l2;
    end

    // Config latch, kernel row count and illegal-start flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_w_q <= '0;
            img_h_q <= '0;
            k_cnt   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= start && (state == IDLE) && cfg_bad;
            if (start_ok) begin
                img_w_q <= cfg_img_w;
                img_h_q <= cfg_img_h;
                k_cnt   <= '0;
            end else if (k_acc) begin
                k_cnt   <= KCNT_W'(k_cnt + KCNT_W'(1));
            end
        end
    end

    // Result delay line: t1 strobes the engine capture, t2 presents the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            {t0, t1, t2} <= '0;
            {l0, l1, l2} <= '0;
        end else begin
            t0 <= px_acc && win_full;
            l0 <= px_acc && last_beat;
            t1 <= t0;
            l1 <= l0;
            t2 <= t1;
            l2 <= l1;
        end
    end

`ifdef CONV5_SEQ_PERF_EN
    // Busy-cycle and input-starvation counters; held after done.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (state != IDLE)                 perf_cycles <= perf_cycles + 32'd1;
            if ((state == STREAM) && !px_valid) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_conv5_seq_ctrl.sv
// Directed bench for conv5_seq_ctrl with a behavioural conv_5 capture stub.
module tb_conv5_seq_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 5 * DW;
    localparam int unsigned CNT_W = 6;
    localparam logic [DW-1:0] ONE_H = 16'h3C00;
    localparam logic [DW-1:0] SUM25 = 16'h4E40;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_img_w;
    logic [CNT_W-1:0] cfg_img_h;
    logic             busy, done, cfg_err;
    logic             k_valid, k_ready;
    logic [BW-1:0]    k_data;
    logic             px_valid, px_ready;
    logic [BW-1:0]    px_data;
    logic [BW-1:0]    conv_data;
    logic             conv_kernel_load, conv_valid_in, conv_valid_out;
    logic [DW-1:0]    conv_data_out;
    logic             res_valid, res_last;
    logic [DW-1:0]    res_data;
`ifdef CONV5_SEQ_PERF_EN
    logic [31:0]      perf_cycles, perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_cyc  [0:1023];
    bit exp_last [0:1023];
    int exp_wr   = 0;
    int exp_rd   = 0;

    int n_res        = 0;
    int n_last       = 0;
    int n_done       = 0;
    int last_res_cyc = 0;
    int done_cyc     = 0;

    always #5 clk = ~clk;

    conv5_seq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_img_w        (cfg_img_w),
        .cfg_img_h        (cfg_img_h),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .k_valid          (k_valid),
        .k_ready          (k_ready),
        .k_data           (k_data),
        .px_valid         (px_valid),
        .px_ready         (px_ready),
        .px_data          (px_data),
        .conv_data        (conv_data),
        .conv_kernel_load (conv_kernel_load),
        .conv_valid_in    (conv_valid_in),
        .conv_valid_out   (conv_valid_out),
        .conv_data_out    (conv_data_out),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .res_last         (res_last)
`ifdef CONV5_SEQ_PERF_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_stalls      (perf_stalls)
`endif
    );

    // Engine stub: conv_reg loads the (all-ones) window sum only when valid_out strobes.
    always @(posedge clk) begin
        if (rst)                 conv_data_out <= '0;
        else if (conv_valid_out) conv_data_out <= SUM25;
        else                     conv_data_out <= '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result monitor: value, arrival cycle and last flag against the driver's expectations.
    always @(negedge clk) begin
        if (rst) begin
            exp_rd = exp_wr;
        end else begin
            if (res_valid) begin
                n_res++;
                last_res_cyc = cyc;
                check_eq("res_data", 32'(res_data), 32'(SUM25));
                if (exp_rd < exp_wr) begin
                    check_eq("res_cycle", cyc, exp_cyc[exp_rd % 1024]);
                    check_eq("res_last", 32'(res_last), 32'(exp_last[exp_rd % 1024]));
                    exp_rd++;
                end else begin
                    check_eq("res_unexpected", 32'(exp_wr - exp_rd), 32'd1);
                end
                if (res_last) n_last++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        cfg_img_w = CNT_W'(w);
        cfg_img_h = CNT_W'(h);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic load_kernel();
        logic [BW-1:0] kd;
        for (int i = 0; i < 5; i++) begin
            kd        = {5{ONE_H}};
            kd[15:0]  = ONE_H + 16'(i);
            k_valid   = 1'b1;
            k_data    = kd;
            #1;
            check_eq("k_ready", 32'(k_ready), 32'd1);
            check_eq("k_valid_in", 32'(conv_valid_in), 32'd1);
            check_eq("k_load", 32'(conv_kernel_load), 32'd1);
            check_eq("k_pass", 32'(conv_data == kd), 32'd1);
            tick();
        end
        k_valid = 1'b0;
    endtask

    // Streams all beats of a job; gap inserts one idle cycle between beats.
    task automatic stream(input int w, input int h, input bit gap, input int inj_at,
                          output int stalls);
        int beat = 0;
        stalls = 0;
        for (int b = 0; b <= h - 5; b++) begin
            for (int c = 0; c < w; c++) begin
                px_valid = 1'b1;
                px_data  = {5{ONE_H}};
                px_data[31:16] = ONE_H + 16'(c);
                if (beat == 0) begin
                    #1;
                    check_eq("px_ready", 32'(px_ready), 32'd1);
                    check_eq("px_pass", 32'(conv_valid_in && (conv_data == px_data)), 32'd1);
                end
                if (c >= 4) begin
                    exp_cyc[exp_wr % 1024]  = cyc + 3;
                    exp_last[exp_wr % 1024] = (b == h - 5) && (c == w - 1);
                    exp_wr++;
                end
                if (beat == inj_at) begin
                    cfg_img_w = CNT_W'(5);
                    cfg_img_h = CNT_W'(5);
                    start     = 1'b1;
                end
                tick();
                start = 1'b0;
                beat++;
                if (gap && !((b == h - 5) && (c == w - 1))) begin
                    px_valid = 1'b0;
                    stalls++;
                    tick();
                end
            end
        end
        px_valid = 1'b0;
    endtask

    task automatic run_job(input int w, input int h, input bit gap, input int inj_at);
        int r0 = n_res;
        int l0 = n_last;
        int d0 = n_done;
        int stalls;
        int n = 0;
        do_start(w, h);
        check_eq("busy_start", 32'(busy), 32'd1);
        load_kernel();
        stream(w, h, gap, inj_at, stalls);
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        tick();
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("res_count", 32'(n_res - r0), 32'((w - 4) * (h - 4)));
        check_eq("last_count", 32'(n_last - l0), 32'd1);
        check_eq("done_count", 32'(n_done - d0), 32'd1);
        check_eq("done_after_res", 32'(done_cyc), 32'(last_res_cyc + 1));
`ifdef CONV5_SEQ_PERF_EN
        check_eq("perf_stalls", perf_stalls, 32'(stalls));
`endif
        $display("job w=%0d h=%0d gap=%0d results=%0d idle_cycles=%0d", w, h, gap, n_res - r0, stalls);
        repeat (2) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_img_w = '0;
        cfg_img_h = '0;
        k_valid   = 1'b0;
        k_data    = '0;
        px_valid  = 1'b0;
        px_data   = '0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_eq("rst_k_ready", 32'(k_ready), 32'd0);
        check_eq("rst_px_ready", 32'(px_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_vout", 32'(conv_valid_out), 32'd0);
        check_eq("rst_kload", 32'(conv_kernel_load), 32'd0);
        rst = 1'b0;
        tick();

        // Minimum image: one window.
        run_job(5, 5, 1'b0, -1);
        // Two bands, back-to-back results.
        run_job(8, 6, 1'b0, -1);
        // Alternating input gaps.
        run_job(8, 6, 1'b1, -1);

        // Illegal configs: width below window, height above maximum.
        do_start(4, 6);
        check_eq("err_w_pulse", 32'(cfg_err), 32'd1);
        check_eq("err_w_busy", 32'(busy), 32'd0);
        check_eq("err_w_k_ready", 32'(k_ready), 32'd0);
        tick();
        check_eq("err_w_clear", 32'(cfg_err), 32'd0);
        check_eq("err_w_idle", 32'(k_ready), 32'd0);
        do_start(8, 33);
        check_eq("err_h_pulse", 32'(cfg_err), 32'd1);
        check_eq("err_h_busy", 32'(busy), 32'd0);
        tick();
        run_job(5, 5, 1'b0, -1);

        // Reset mid-stream at band 0, col 6.
        r0 = n_res;
        do_start(8, 6);
        load_kernel();
        for (int c = 0; c < 6; c++) begin
            px_valid = 1'b1;
            px_data  = {5{ONE_H}};
            if (c >= 4) begin
                exp_cyc[exp_wr % 1024]  = cyc + 3;
                exp_last[exp_wr % 1024] = 1'b0;
                exp_wr++;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_px_ready", 32'(px_ready), 32'd0);
        check_eq("mid_rst_valid_in", 32'(conv_valid_in), 32'd0);
        check_eq("mid_rst_data", 32'(conv_data == '0), 32'd1);
        check_eq("mid_rst_vout", 32'(conv_valid_out), 32'd0);
        check_eq("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("mid_rst_res_data", 32'(res_data), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        rst      = 1'b0;
        px_valid = 1'b0;
        repeat (4) tick();
        check_eq("mid_rst_no_res", 32'(n_res - r0), 32'd0);
        run_job(8, 6, 1'b0, -1);

        // Start pulse while busy (would be a 5x5 job) must be ignored.
        run_job(8, 6, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv5_seq_ctrl.md
Name: conv5_seq_ctrl

Overview:
Sequencer for the 5x5 FP16 convolution engine (conv_5).
- Each job first loads the 5 kernel rows from a kernel stream.
- It then streams the image as 5-pixel beats, one band of 5 rows at a time.
- It drives the engine's kernel_load, valid_in and valid_out at the correct cycles and returns each completed window result with valid/last flags.
- Position: between the line-buffer/weight fetch logic and one conv_5 instance.

Parameters:
DATA_WIDTH, 16, FP16 element width
KERNEL_SIZE, 5, window size; fixed by the engine, other values unsupported
IMG_MAX, 32, maximum image width/height (matches CONV_LENGTH)
CNT_W, $clog2(IMG_MAX+1), width of config and position counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle job start pulse
cfg_img_w  in  CNT_W  image width W; sampled on start
cfg_img_h  in  CNT_W  image height H; sampled on start
busy  out  1  job in progress
done  out  1  one-cycle pulse at end of job
cfg_err  out  1  one-cycle pulse when start has illegal config
k_valid  in  1  kernel row beat valid
k_ready  out  1  kernel row beat accepted
k_data  in  5*DATA_WIDTH  kernel row; element j at bits [(j+1)*DW-1 -: DW]
px_valid  in  1  pixel beat valid
px_ready  out  1  pixel beat accepted
px_data  in  5*DATA_WIDTH  5 vertically adjacent pixels, same packing as k_data
conv_data  out  5*DATA_WIDTH  to engine data_in0..4 (element j -> data_inj)
conv_kernel_load  out  1  engine kernel_load
conv_valid_in  out  1  engine valid_in
conv_valid_out  out  1  engine valid_out
conv_data_out  in  DATA_WIDTH  engine data_out
res_valid  out  1  result valid
res_data  out  DATA_WIDTH  convolution result
res_last  out  1  marks the final result of the job

Behaviour:
Reset and job control:
- Reset (any state, including mid-job) forces the following:
  - state IDLE
  - all counters and the delay line cleared
  - every output 0
- A start pulse while busy is ignored.
- On start in IDLE:
  - W<5, H<5, W>IMG_MAX or H>IMG_MAX: pulse cfg_err the next cycle and stay in IDLE.
  - Otherwise latch W and H, go to LOAD_K, and set busy=1.

FSM states:
- IDLE: k_ready=0, px_ready=0.
- LOAD_K:
  - k_ready=1, conv_kernel_load=1.
  - conv_valid_in = k_valid & k_ready; conv_data = k_data (combinational pass-through).
  - Count 5 accepted beats, then go to STREAM.
  - The first beat accepted becomes engine kernel row 0.
- STREAM:
  - px_ready=1, conv_kernel_load=0.
  - conv_valid_in = px_valid & px_ready; conv_data = px_data.
  - Counters: col 0..W-1 and band 0..H-5. col increments per accepted beat. At col=W-1 it wraps to 0 and band increments.
  - After the accepted beat with band=H-5 and col=W-1, go to DRAIN.
- DRAIN:
  - px_ready=0.
  - Wait until the delay line is empty, then pulse done, clear busy, return to IDLE.
- Gaps: px_valid and k_valid gaps stall the counters only. Full throughput is 1 beat/cycle.

Result pipeline (3-stage delay line t0, t1, t2):
- An accepted STREAM beat with col>=4 sets t0. t1 and t2 follow one cycle later each.
- conv_valid_out = t1, so the engine's conv_reg captures the window sum at the next edge.
- res_valid = t2, with res_data = conv_data_out.
- res_last = t2 on the result produced from the final beat.
- Latency: 3 cycles from beat acceptance to res_valid. Back-to-back results are supported.
- No output backpressure; the sink must accept every result.

Counts per job:
- Band start: cols 0..3 of every band only prime the window and produce no result, even though stale data sits in the engine.
- Results per band: W-4. Total results: (W-4)*(H-4).

Optional Feature:
Macro CONV5_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] (cycles with busy=1) and perf_stalls[31:0] (STREAM cycles with px_valid=0).
  - Both clear on accepted start and on rst, and hold after done.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
Package conv5_pkg holds:
- the state enum (IDLE, LOAD_K, STREAM, DRAIN)
- KERNEL_SIZE and the FP16 width constant
- typedef beat_t = logic [5*16-1:0]

One natural sub-module, conv5_pos_cnt:
- col/band counters with wrap detection and a last-beat flag
- inputs: advance, W, H; outputs: col, band, win_full, last_beat

Test Plan:
- W=5,H=5, kernel all 0x3C00, pixels all 0x3C00 -> exactly 1 result 0x4E40 (25.0) with res_last=1, done 1 cycle after res_valid, busy low after.
- W=8,H=6, same data -> 8 results, each 0x4E40, each 3 cycles after its beat (cols 4..7 of bands 0,1); res_last on the 8th only; no result for cols 0..3 of band 1.
- W=8,H=6 with px_valid toggled 1,0,1,0 -> same 8 values, same count; spacing follows the input gaps; perf_stalls (if enabled) equals the number of idle STREAM cycles.
- start with cfg_img_w=4 -> cfg_err pulse, k_ready stays 0, busy stays 0; a following legal start proceeds normally.
- rst asserted mid-STREAM (band 0, col 6) -> next cycle all outputs 0, state IDLE; a new job on the same engine gives correct results.
- start pulsed while busy -> ignored; result count and done timing unchanged.
